// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational access checking, store lane replication and load lane extraction.
module lsu_align
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 256
) (
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic [32:0] addr_diff;
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Borrow out of the 33-bit subtraction means the address lies below the base.
  assign addr_diff = {1'b0, req_addr} - {1'b0, DMEM_BASE};
  assign range_ok  = !addr_diff[32] && (addr_diff[31:0] < 32'(DMEM_BYTES));

  always_comb begin
    if (req_we) begin
      f3_ok = req_funct3 inside {F3_SB, F3_SH, F3_SW};
    end else begin
      f3_ok = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    end
  end

  always_comb begin
    align_ok = 1'b1;
    case (req_funct3[1:0])
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign req_legal = f3_ok && align_ok && range_ok;

  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  assign ld_shift = ld_word >> {ld_off, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: turns one core data access into one word-aligned valid/ready bus transaction.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_t  state_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;
  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [31:0] ld_data;

  lsu_align #(
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_BYTES (DMEM_BYTES)
  ) u_align (
    .req_we        (mem_we),
    .req_funct3    (mem_funct3),
    .req_addr      (mem_addr),
    .req_wdata     (mem_wdata),
    .req_legal     (req_legal),
    .req_be        (req_be),
    .req_wdata_rep (req_wdata_rep),
    .ld_funct3     (ld_funct3_q),
    .ld_off        (ld_off_q),
    .ld_word       (bus_rdata),
    .ld_data       (ld_data)
  );

  // Gated by reset so the core is never held while the unit is being reset.
  assign mem_stall = reset && (((state_q == StIdle) && mem_req) ||
                               (state_q == StReq) || (state_q == StWaitR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ld_funct3_q <= 3'b000;
      ld_off_q    <= 2'b00;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_be      <= 4'h0;
      bus_wdata   <= 32'h0;
      mem_rdata   <= 32'h0;
      mem_fault   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req) begin
            if (!req_legal) begin
              mem_fault <= 1'b1;
              mem_rdata <= 32'h0;
              state_q   <= StDone;
            end else begin
              bus_valid   <= 1'b1;
              bus_we      <= mem_we;
              bus_addr    <= {mem_addr[31:2], 2'b00};
              bus_be      <= req_be;
              bus_wdata   <= req_wdata_rep;
              ld_funct3_q <= mem_funct3;
              ld_off_q    <= mem_addr[1:0];
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_we) begin
              mem_fault <= 1'b0;
              mem_rdata <= 32'h0;
              state_q   <= StDone;
            end else begin
              state_q <= StWaitR;
            end
          end
        end
        StWaitR: begin
          if (bus_rvalid) begin
            mem_fault <= 1'b0;
            mem_rdata <= ld_data;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: drives core accesses and a scripted bus responder.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_fault;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(
    .DMEM_BASE  (32'h0000_0000),
    .DMEM_BYTES (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Observations of the last access.
  int          r_stalls;
  int          r_nvalid;
  logic        r_stable;
  logic        r_fault;
  logic        r_we;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Run one access; the responder accepts after rdy_dly REQ cycles and answers a load
  // rsp_dly cycles after entering WAIT_R. Stray ready/rvalid are injected where ignorable.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rsp_data);
    int req_cnt;
    int rsp_cnt;
    bit accepted;
    bit done;
    @(posedge clk);
    #1;
    mem_req    = 1'b1;
    mem_we     = we;
    mem_funct3 = f3;
    mem_addr   = addr;
    mem_wdata  = wdata;
    r_stalls = 0;
    r_nvalid = 0;
    r_stable = 1'b1;
    r_fault  = 1'bx;
    r_rdata  = 32'hx;
    r_we     = 1'b0;
    r_be     = 4'h0;
    r_addr   = 32'h0;
    r_wdata  = 32'h0;
    req_cnt  = 0;
    rsp_cnt  = 0;
    accepted = 1'b0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done       = 1'b1;
        r_fault    = mem_fault;
        r_rdata    = mem_rdata;
        mem_req    = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
      end else begin
        r_stalls++;
        if (bus_valid) begin
          if (r_nvalid == 0) begin
            r_be    = bus_be;
            r_addr  = bus_addr;
            r_wdata = bus_wdata;
            r_we    = bus_we;
          end else if (bus_be !== r_be || bus_addr !== r_addr || bus_wdata !== r_wdata ||
                       bus_we !== r_we) begin
            r_stable = 1'b0;
          end
          r_nvalid++;
          if (req_cnt == rdy_dly) begin
            bus_ready  = 1'b1;
            bus_rvalid = 1'b0;
            accepted   = 1'b1;
          end else begin
            bus_ready  = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hDEAD_BEEF;
            req_cnt++;
          end
        end else if (!accepted) begin
          bus_ready  = 1'b1;
          bus_rvalid = 1'b1;
          bus_rdata  = 32'hDEAD_BEEF;
        end else begin
          bus_ready  = 1'b0;
          bus_rvalid = (rsp_cnt == rsp_dly);
          bus_rdata  = rsp_data;
          rsp_cnt++;
        end
      end
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      mem_req    = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
    end
  endtask

  task automatic chk_done(input string tag, input int stalls, input int nvalid,
                          input logic fault, input logic [31:0] rdata);
    check({tag, "_stall"}, 32'(r_stalls), 32'(stalls));
    check({tag, "_nvalid"}, 32'(r_nvalid), 32'(nvalid));
    check({tag, "_fault"}, {31'h0, r_fault}, {31'h0, fault});
    check({tag, "_rdata"}, r_rdata, rdata);
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    check({tag, "_we"}, {31'h0, r_we}, {31'h0, we});
    check({tag, "_addr"}, r_addr, addr);
    check({tag, "_be"}, {28'h0, r_be}, {28'h0, be});
    if (we) check({tag, "_wdata"}, r_wdata, wdata);
  endtask

  initial begin
    reset      = 1'b0;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    mem_funct3 = F3_LW;
    mem_addr   = 32'h40;
    mem_wdata  = 32'h0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;

    // Reset state, with a pending request that must not stall the core.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_valid", {31'h0, bus_valid}, 32'h0);
    check("rst_we", {31'h0, bus_we}, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", {28'h0, bus_be}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_fault", {31'h0, mem_fault}, 32'h0);
    mem_req = 1'b0;
    reset   = 1'b1;

    access(1'b1, F3_SW, 32'h60, 32'h0000_0019, 0, 0, 32'h0);
    chk_done("sw60", 2, 1, 1'b0, 32'h0);
    chk_bus("sw60", 1'b1, 32'h60, 4'b1111, 32'h0000_0019);

    access(1'b1, F3_SB, 32'h65, 32'hABCD_EF80, 0, 0, 32'h0);
    chk_done("sb65", 2, 1, 1'b0, 32'h0);
    chk_bus("sb65", 1'b1, 32'h64, 4'b0010, 32'h8080_8080);

    access(1'b0, F3_LB, 32'h66, 32'h0, 0, 2, 32'h1280_3456);
    chk_done("lb66", 5, 1, 1'b0, 32'hFFFF_FF80);
    chk_bus("lb66", 1'b0, 32'h64, 4'b0100, 32'h0);

    access(1'b0, F3_LBU, 32'h66, 32'h0, 0, 2, 32'h1280_3456);
    chk_done("lbu66", 5, 1, 1'b0, 32'h0000_0080);
    @(negedge clk);
    check("rdata_hold", mem_rdata, 32'h0000_0080);

    access(1'b0, F3_LH, 32'h61, 32'h0, 0, 0, 32'h0);
    chk_done("lh61", 1, 0, 1'b1, 32'h0);

    access(1'b0, F3_LW, 32'h102, 32'h0, 0, 0, 32'h0);
    chk_done("lw102", 1, 0, 1'b1, 32'h0);

    access(1'b0, F3_LHU, 32'h62, 32'h0, 5, 0, 32'h8001_7FFF);
    chk_done("lhu62", 8, 6, 1'b0, 32'h0000_8001);
    chk_bus("lhu62", 1'b0, 32'h60, 4'b1100, 32'h0);
    check("lhu62_stable", {31'h0, r_stable}, 32'h1);

    access(1'b0, F3_LH, 32'h60, 32'h0, 1, 0, 32'h8001_F234);
    chk_done("lh60", 4, 2, 1'b0, 32'hFFFF_F234);
    check("lh60_be", {28'h0, r_be}, 32'h3);

    access(1'b1, F3_SH, 32'h7E, 32'h1234_5678, 0, 0, 32'h0);
    chk_done("sh7e", 2, 1, 1'b0, 32'h0);
    chk_bus("sh7e", 1'b1, 32'h7C, 4'b1100, 32'h5678_5678);

    access(1'b0, F3_LW, 32'hFC, 32'h0, 0, 0, 32'hCAFE_F00D);
    chk_done("lwfc", 3, 1, 1'b0, 32'hCAFE_F00D);

    access(1'b1, F3_SW, 32'h100, 32'h1, 0, 0, 32'h0);
    chk_done("sw100", 1, 0, 1'b1, 32'h0);

    access(1'b0, 3'b011, 32'h10, 32'h0, 0, 0, 32'h0);
    chk_done("ld_f3_011", 1, 0, 1'b1, 32'h0);

    access(1'b1, 3'b100, 32'h10, 32'h0, 0, 0, 32'h0);
    chk_done("st_f3_100", 1, 0, 1'b1, 32'h0);

    access(1'b0, F3_LW, 32'h62, 32'h0, 0, 0, 32'h0);
    chk_done("lw62", 1, 0, 1'b1, 32'h0);

    // Reset while waiting for a read response.
    @(posedge clk);
    #1;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    mem_funct3 = F3_LW;
    mem_addr   = 32'h40;
    bus_ready  = 1'b0;
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    check("wr_reqvalid", {31'h0, bus_valid}, 32'h1);
    @(negedge clk);
    bus_ready = 1'b0;
    check("wr_stall", {31'h0, mem_stall}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("wr_rst_valid", {31'h0, bus_valid}, 32'h0);
    check("wr_rst_stall", {31'h0, mem_stall}, 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1111_1111;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("late_rsp_rdata", mem_rdata, 32'h0);
    check("late_rsp_stall", {31'h0, mem_stall}, 32'h0);

    access(1'b1, F3_SW, 32'h44, 32'h5555_AAAA, 0, 0, 32'h0);
    chk_done("sw44", 2, 1, 1'b0, 32'h0);
    chk_bus("sw44", 1'b1, 32'h44, 4'b1111, 32'h5555_AAAA);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit between the core's data-memory port and a variable-latency data bus with a valid/ready request channel and a separate read-response channel. It converts each lw/lh/lb/lhu/lbu/sw/sh/sb into one word-aligned bus transaction with byte enables, and formats load data with sign or zero extension. While the transaction is in flight it asserts mem_stall so the core holds PC. Misaligned, out-of-range or illegal-funct3 accesses are faulted without any bus activity.

Parameters:
DMEM_BASE, 32'h0000_0000, byte address of the first valid data location
DMEM_BYTES, 256, size of the data region in bytes; a power of two and a multiple of 4

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
mem_req  in  1  core has a load/store this cycle; held stable while mem_stall=1
mem_we  in  1  1=store, 0=load
mem_funct3  in  3  instruction funct3 (access size and signedness)
mem_addr  in  32  byte address (ALU result)
mem_wdata  in  32  store data (rs2)
mem_rdata  out  32  formatted load data; valid in DONE
mem_stall  out  1  core must not advance
mem_fault  out  1  access rejected; valid in DONE
bus_valid  out  1  request valid
bus_ready  in  1  request accepted when bus_valid & bus_ready
bus_we  out  1  request is a write
bus_addr  out  32  word address {mem_addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated write data
bus_rvalid  in  1  read response valid, single cycle
bus_rdata  in  32  read response word

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE. Reset value is IDLE.
- Reset values: bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, mem_rdata=0, mem_fault=0. mem_stall=0 while reset is asserted.
- mem_stall is combinational: asserted in IDLE when mem_req=1, and in REQ and WAIT_R. It is 0 in DONE.
- IDLE with mem_req=1:
  - If the access is illegal, go to DONE with mem_fault=1 and mem_rdata=0. No bus request is issued.
  - Otherwise register bus_we/bus_addr/bus_be/bus_wdata and go to REQ.
- Illegal access is any of:
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010};
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr outside [DMEM_BASE, DMEM_BASE+DMEM_BYTES).
- REQ: bus_valid=1. The request fields are stable until acceptance, and bus_valid is never withdrawn before acceptance.
  - On bus_ready: a store goes to DONE; a load goes to WAIT_R.
  - bus_rvalid in REQ is ignored.
- WAIT_R: on bus_rvalid, capture the formatted bus_rdata into mem_rdata and go to DONE. Wait is unbounded.
- DONE: lasts exactly one cycle, then IDLE. The core advances on this edge.
  - mem_fault and mem_rdata hold until the next DONE.
  - On a store, mem_rdata=0.
- Byte enables and write data, with byte offset o=addr[1:0]:
  - byte: be=4'b0001<<o, wdata={4{wdata[7:0]}};
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}};
  - word: be=4'b1111, wdata unchanged.
  - Loads drive the same be pattern.
- Load format: select the lane by o.
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: word unchanged.
- Latency, counted from mem_req to the core advancing:
  - legal store with bus_ready in the first REQ cycle: 3 cycles (2 stall cycles);
  - load: 3 cycles plus response delay;
  - fault: 2 cycles (1 stall cycle).
- Stray inputs: bus_rvalid in IDLE or DONE is ignored. bus_ready while bus_valid=0 is ignored.
- Asynchronous reset mid-transaction: immediately return to IDLE and drop bus_valid. Any response that arrives later is ignored.
- Back-to-back accesses: a new mem_req seen in IDLE, directly after DONE, starts a new transaction. There are no idle bubbles beyond the IDLE cycle.

Decomposition:
- Package lsu_pkg holds:
  - the state enum typedef lsu_state_t;
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
- Combinational sub-module lsu_align holds:
  - legality check;
  - be/wdata generation;
  - load-lane extract and extend.
  The FSM and registers stay in lsu_bus_ctrl.

Test Plan:
- sw at 0x60, data 0x0000_0019, bus_ready asserted immediately -> bus_addr=0x60, be=4'b1111, wdata=0x19; mem_stall high for 2 cycles; DONE with mem_fault=0.
- sb at 0x65, data 0xABCD_EF80 -> be=4'b0010, bus_wdata=0x8080_8080.
- lb and lbu at 0x66, bus_rdata=0x1280_3456, rvalid 3 cycles after accept -> lb gives mem_rdata=0xFFFF_FF80; lbu gives 0x0000_0080; mem_stall deasserts only in DONE.
- lh at 0x61 and lw at 0x102 (beyond 256 bytes) -> bus_valid never rises; mem_fault=1 in DONE; mem_rdata=0; 1 stall cycle.
- Load with bus_ready low for 5 cycles -> bus_valid, bus_addr and bus_be are stable throughout; stray rvalid during REQ is ignored.
- Reset asserted in WAIT_R -> bus_valid=0 and mem_stall=0 immediately; a following rvalid is ignored; a new sw after release completes normally.
